// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two block sources, the arbiter and the UART controller.
interface uart_tx_arbiter_if #(
   parameter int N_AES = 128
);
   logic             aes_valid;
   logic [N_AES-1:0] aes_data;
   logic             aes_ready;
   logic             pt_valid;
   logic [N_AES-1:0] pt_data;
   logic             pt_ready;
   logic             uc_start;
   logic [N_AES-1:0] uc_in;
   logic             uc_write;
   logic             grant_id;
   logic             busy;
   logic             timeout;

   modport slave (
      input  aes_valid, aes_data, pt_valid, pt_data, uc_write,
      output aes_ready, pt_ready, uc_start, uc_in, grant_id, busy, timeout
   );

   modport master (
      output aes_valid, aes_data, pt_valid, pt_data, uc_write,
      input  aes_ready, pt_ready, uc_start, uc_in, grant_id, busy, timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding AES and plaintext blocks to a word-serial UART controller.
// Define UART_ARB_WATCHDOG_EN to compile in the drain watchdog (TIMEOUT_CYCLES).
module uart_tx_arbiter #(
   parameter int N_AES          = 128,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   uart_tx_arbiter_if.slave  bus
);
   localparam int WORDS = N_AES / DATA_WIDTH;
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   if ((N_AES % DATA_WIDTH) != 0) begin : g_bad_width
      $error("N_AES must be a multiple of DATA_WIDTH");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_DRAIN} state_t;

   state_t           state_q, state_d;
   logic             aes_full_q, aes_full_d;
   logic             pt_full_q, pt_full_d;
   logic [N_AES-1:0] aes_buf_q, aes_buf_d;
   logic [N_AES-1:0] pt_buf_q, pt_buf_d;
   logic             grant_q, grant_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done;
   logic             timeout_pulse;

`ifdef UART_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
`endif

   always_comb begin
      state_d       = state_q;
      aes_full_d    = aes_full_q;
      pt_full_d     = pt_full_q;
      aes_buf_d     = aes_buf_q;
      pt_buf_d      = pt_buf_q;
      grant_d       = grant_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      done          = 1'b0;
      timeout_pulse = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
      wd_d          = wd_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (aes_full_q || pt_full_q) begin
               // Tie goes to whichever channel was not served last.
               grant_d = aes_full_q ? (pt_full_q ? ~last_q : 1'b0) : 1'b1;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_DRAIN;
`ifdef UART_ARB_WATCHDOG_EN
            wd_d    = WD_W'(1);
`endif
         end
         S_DRAIN: begin
            if (bus.uc_write) begin
               if (cnt_q == LAST_WORD) done = 1'b1;
               else                    cnt_d = cnt_q + CNT_W'(1);
`ifdef UART_ARB_WATCHDOG_EN
               wd_d = WD_W'(1);
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
               timeout_pulse = 1'b1;
               done          = 1'b1;
            end else begin
               wd_d = wd_q + WD_W'(1);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (done) begin
         cnt_d   = '0;
         last_d  = grant_q;
         state_d = S_IDLE;
         if (grant_q) pt_full_d  = 1'b0;
         else         aes_full_d = 1'b0;
      end

      // A full buffer cannot accept, so capture never collides with the release above.
      if (bus.aes_valid && !aes_full_q) begin
         aes_full_d = 1'b1;
         aes_buf_d  = bus.aes_data;
      end
      if (bus.pt_valid && !pt_full_q) begin
         pt_full_d = 1'b1;
         pt_buf_d  = bus.pt_data;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= S_IDLE;
         aes_full_q <= 1'b0;
         pt_full_q  <= 1'b0;
         aes_buf_q  <= '0;
         pt_buf_q   <= '0;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
`ifdef UART_ARB_WATCHDOG_EN
         wd_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         aes_full_q <= aes_full_d;
         pt_full_q  <= pt_full_d;
         aes_buf_q  <= aes_buf_d;
         pt_buf_q   <= pt_buf_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
`ifdef UART_ARB_WATCHDOG_EN
         wd_q       <= wd_d;
`endif
      end
   end

   assign bus.aes_ready = ~aes_full_q;
   assign bus.pt_ready  = ~pt_full_q;
   assign bus.uc_start  = (state_q == S_LAUNCH);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.grant_id  = grant_q;
   assign bus.uc_in     = (state_q == S_IDLE) ? '0 : (grant_q ? pt_buf_q : aes_buf_q);
`ifdef UART_ARB_WATCHDOG_EN
   assign bus.timeout   = timeout_pulse;
`else
   assign bus.timeout   = 1'b0;
`endif
endmodule
